// File: rtl/alu_share_sequencer.sv
// rtl/alu_share_sequencer.sv - round-robin sharing of one combinational flagged ALU between two requesters
module alu_share_sequencer #(
  parameter bit ACC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic [1:0] req0_cant,
  input  logic       req0_acc,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  input  logic [1:0] req1_cant,
  input  logic       req1_acc,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] alu_cant,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_negative,
  input  logic       alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state, state_nx;
  logic       last_grant;
  logic       owner;
  logic [7:0] acc0, acc1;
  logic       grant0, grant1;
  logic       use_acc0, use_acc1;

  // On contention the requester that did not win last time gets the ALU.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign use_acc0   = ACC_EN && req0_acc;
  assign use_acc1   = ACC_EN && req1_acc;
  assign req0_ready = !rst && (state == IDLE) && grant0;
  assign req1_ready = !rst && (state == IDLE) && grant1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nx = EXEC;
      EXEC:    state_nx = HOLD;
      HOLD:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      acc0       <= 8'h00;
      acc1       <= 8'h00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_ctrl   <= 3'b000;
      alu_cant   <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 8'h00;
      rsp_flags  <= 4'h0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (grant0) begin
            alu_a      <= use_acc0 ? acc0 : req0_a;
            alu_b      <= req0_b;
            alu_ctrl   <= req0_op;
            alu_cant   <= req0_cant;
            owner      <= 1'b0;
            last_grant <= 1'b0;
          end else if (grant1) begin
            alu_a      <= use_acc1 ? acc1 : req1_a;
            alu_b      <= req1_b;
            alu_ctrl   <= req1_op;
            alu_cant   <= req1_cant;
            owner      <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        EXEC: begin
          // ALU has had a full cycle to settle on the registered operands.
          rsp_valid  <= 1'b1;
          rsp_id     <= owner;
          rsp_result <= alu_result;
          rsp_flags  <= {alu_carry, alu_overflow, alu_negative, alu_zero};
          if (owner) acc1 <= alu_result;
          else       acc0 <= alu_result;
        end
        HOLD: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sequencer.sv
// tb/tb_alu_share_sequencer.sv - directed and randomized checks of alu_share_sequencer against a transaction-level model
module tb_alu_share_sequencer;

  localparam bit ACC_EN = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [1:0] req0_cant, req1_cant;
  logic       req0_acc, req1_acc;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_ctrl;
  logic [1:0] alu_cant;
  logic       alu_carry, alu_overflow, alu_negative, alu_zero;

  int total = 0;
  int bad = 0;
  logic [7:0] acc_m [2];

  always #5 clk = ~clk;

  // Returns {carry, overflow, negative, zero, result}.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      default: r = a;
    endcase
    return {c, v, r[7], (r == 8'h00), r};
  endfunction

  assign {alu_carry, alu_overflow, alu_negative, alu_zero, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

  alu_share_sequencer #(.ACC_EN(ACC_EN)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cant(req0_cant), .req0_acc(req0_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cant(req1_cant), .req1_acc(req1_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_cant(alu_cant),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic [1:0] cant, input logic acc);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_cant = cant; req0_acc = acc;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_cant = cant; req1_acc = acc;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(0, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    drive_req(1, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    tick;
    tick;
    rst = 1'b0;
    acc_m[0] = 8'h00;
    acc_m[1] = 8'h00;
  endtask

  // One operation through the requester port; leaves the block in HOLD when rsp_ready is low.
  task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [1:0] cant, input logic acc, output logic [7:0] r, output logic [3:0] f);
    logic [11:0] e;
    logic [7:0]  ea;
    logic        rdy;
    int          n;
    drive_req(id, 1'b1, a, b, op, cant, acc);
    #1;
    n = 0;
    rdy = (id == 0) ? req0_ready : req1_ready;
    while (!rdy && n < 8) begin
      tick;
      #1;
      n++;
      rdy = (id == 0) ? req0_ready : req1_ready;
    end
    chk("accept_ready", rdy, 1);
    ea = (acc && ACC_EN) ? acc_m[id] : a;
    e = alu_ref(ea, b, op);
    tick;
    drive_req(id, 1'b0, a, b, op, cant, acc);
    #1;
    chk("ready_one_cycle", (id == 0) ? req0_ready : req1_ready, 0);
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, b);
    chk("alu_ctrl", alu_ctrl, op);
    chk("alu_cant", alu_cant, cant);
    chk("rsp_valid_exec", rsp_valid, 0);
    tick;
    chk("rsp_valid_latency", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_result", rsp_result, e[7:0]);
    chk("rsp_flags", rsp_flags, e[11:8]);
    r = rsp_result;
    f = rsp_flags;
    acc_m[id] = e[7:0];
    if (rsp_ready) begin
      tick;
      chk("rsp_valid_drop", rsp_valid, 0);
    end
  endtask

  initial begin
    logic [7:0]  r;
    logic [3:0]  f;
    logic [11:0] e;
    logic [11:0] qexp [$];
    logic        qid [$];
    int          na, nr, last_acc, g, exp_g;

    // Reset state, and readies masked while rst is high.
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req(0, 1'b1, 8'h11, 8'h22, 3'b001, 2'b01, 1'b0);
    drive_req(1, 1'b1, 8'h33, 8'h44, 3'b000, 2'b10, 1'b0);
    tick;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    do_reset;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_bus", {rsp_id, rsp_result, rsp_flags}, 0);
    chk("rst_alu_bus", {alu_a, alu_b, alu_ctrl, alu_cant}, 0);

    // Single request and wrap/flags vectors.
    rsp_ready = 1'b1;
    do_op(0, 8'h05, 8'h03, 3'b000, 2'b00, 1'b0, r, f);
    chk("single_result", r, 8'h08);
    chk("single_flags", f, 4'b0000);
    do_op(1, 8'hFF, 8'h01, 3'b000, 2'b00, 1'b0, r, f);
    chk("wrap_result", r, 8'h00);
    chk("wrap_flags", f, 4'b1001);

    // Contention from reset: strict alternation starting at 0, one accept every 3 cycles.
    do_reset;
    rsp_ready = 1'b1;
    drive_req(0, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 2'($urandom), 1'b0);
    drive_req(1, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 2'($urandom), 1'b0);
    na = 0; nr = 0; last_acc = -1; exp_g = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rsp_valid) begin
        chk("cont_rsp_expected", qexp.size() > 0, 1);
        if (qexp.size() > 0) begin
          chk("cont_rsp_id", rsp_id, qid.pop_front());
          e = qexp.pop_front();
          chk("cont_rsp_result", rsp_result, e[7:0]);
          chk("cont_rsp_flags", rsp_flags, e[11:8]);
        end
        nr++;
      end
      if (req0_ready || req1_ready) begin
        chk("cont_single_grant", req0_ready && req1_ready, 0);
        g = req1_ready ? 1 : 0;
        chk("cont_grant_order", g, exp_g);
        exp_g ^= 1;
        if (last_acc >= 0) chk("cont_spacing", c - last_acc, 3);
        last_acc = c;
        qid.push_back(g[0]);
        qexp.push_back(g == 0 ? alu_ref(req0_a, req0_b, req0_op) : alu_ref(req1_a, req1_b, req1_op));
        na++;
        tick;
        drive_req(g, 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 2'($urandom), 1'b0);
      end else begin
        tick;
      end
    end
    drive_req(0, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    drive_req(1, 1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
    chk("cont_accepts", na, 4);
    chk("cont_responses", nr, 4);

    // Accumulate: acc1 is independent of req0 traffic.
    do_reset;
    rsp_ready = 1'b1;
    do_op(0, 8'h10, 8'h01, 3'b000, 2'b00, 1'b0, r, f);
    chk("acc_first", r, 8'h11);
    do_op(0, 8'hEE, 8'h02, 3'b000, 2'b00, 1'b1, r, f);
    chk("acc_chain", r, 8'h13);
    do_op(1, 8'h77, 8'h01, 3'b000, 2'b00, 1'b1, r, f);
    chk("acc_other", r, 8'h01);

    // Backpressure: stall in HOLD, pending requests not accepted.
    rsp_ready = 1'b0;
    do_op(1, 8'h40, 8'h05, 3'b001, 2'b11, 1'b0, r, f);
    drive_req(0, 1'b1, 8'h01, 8'h01, 3'b000, 2'b00, 1'b0);
    drive_req(1, 1'b1, 8'h02, 8'h02, 3'b000, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_stable", {rsp_id, rsp_result, rsp_flags}, {1'b1, r, f});
      chk("bp_readies", {req0_ready, req1_ready}, 2'b00);
    end
    drive_req(0, 1'b0, 8'h01, 8'h01, 3'b000, 2'b00, 1'b0);
    drive_req(1, 1'b0, 8'h02, 8'h02, 3'b000, 2'b00, 1'b0);
    rsp_ready = 1'b1;
    tick;
    chk("bp_release", rsp_valid, 0);
    req0_valid = 1'b1;
    #1;
    chk("bp_idle_after", req0_ready, 1);
    req0_valid = 1'b0;
    tick;

    // Randomized traffic against the model.
    do_reset;
    rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      do_op(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)),
            2'($urandom), 1'($urandom), r, f);
    end

    // Reset while holding a response clears everything, accumulators included.
    do_op(0, 8'h30, 8'h01, 3'b000, 2'b00, 1'b0, r, f);
    rsp_ready = 1'b0;
    do_op(1, 8'h90, 8'h20, 3'b000, 2'b01, 1'b0, r, f);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    acc_m[0] = 8'h00;
    acc_m[1] = 8'h00;
    chk("hold_rst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, 0);
    chk("hold_rst_alu", {alu_a, alu_b, alu_ctrl, alu_cant}, 0);
    rsp_ready = 1'b1;
    do_op(0, 8'hAA, 8'h04, 3'b000, 2'b00, 1'b1, r, f);
    chk("hold_rst_acc_cleared", r, 8'h04);

    // Reset coinciding with a would-be accept: nothing is taken.
    rst = 1'b1;
    drive_req(0, 1'b1, 8'h5A, 8'h0F, 3'b011, 2'b10, 1'b0);
    #1;
    chk("rst_win_ready", req0_ready, 0);
    tick;
    rst = 1'b0;
    drive_req(0, 1'b0, 8'h5A, 8'h0F, 3'b011, 2'b10, 1'b0);
    tick;
    chk("rst_win_alu", {alu_a, alu_b, alu_ctrl}, 0);
    tick;
    chk("rst_win_no_rsp", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
